dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_counter.sv | 27 ++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state,
// word stride and default bus widths.
package dmem_arbiter_pkg;

    localparam int DEF_AW   = 32;
    localparam int DEF_DW   = 32;
    localparam int WORD_INC = 4;
    localparam int BEAT_W   = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_arbiter_counter.sv
// Generic up-counter with synchronous clear (clear wins over enable);
// counts DMA beats issued after beat 0.
module dmem_arbiter_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: single-beat CPU accesses against DMA bursts,
// with a starvation limit that hands the memory to a waiting DMA.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [3:0]    dma_len,
    output logic          dma_gnt,
    output logic          dma_beat,
    output logic          dma_done,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output state_e        dbg_state,
    output logic [7:0]    dbg_starve_cnt
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_e              state_q;
    logic [7:0]          starve_q;
    logic [BEAT_W-1:0]   len_q;
    logic [AW-1:0]       base_q;
    logic                we_q;
    logic [AW-1:0]       addr_last_q;
    logic [DW-1:0]       wdata_last_q;
    logic                cpu_rvalid_q;
    logic                dma_rvalid_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_idx;
    logic                cpu_win;
    logic                dma_win;
    logic                burst_beat;
    logic                burst_last;

    dmem_arbiter_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (dma_win),
        .en_i    (burst_beat),
        .count_o (beat_cnt)
    );

    // Counter holds beats issued since beat 0, so the beat now on the bus is one ahead.
    assign beat_idx = beat_cnt + 4'd1;

    always_comb begin
        cpu_win    = 1'b0;
        dma_win    = 1'b0;
        burst_beat = 1'b0;
        burst_last = 1'b0;
        if (reset_n) begin
            if (state_q == S_IDLE) begin
                cpu_win = cpu_req && (!dma_req || (starve_q < STARVE_LIM));
                dma_win = dma_req && !cpu_win;
            end else begin
                burst_beat = 1'b1;
                burst_last = (beat_idx == len_q);
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_last_q;
        mem_wdata = wdata_last_q;
        if (cpu_win) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_win) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (burst_beat) begin
            mem_we    = we_q;
            mem_addr  = base_q + (AW'(beat_idx) * AW'(WORD_INC));
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt   = cpu_win;
    assign cpu_stall = cpu_req & ~cpu_win;
    assign dma_gnt   = dma_win;
    assign dma_beat  = dma_win | burst_beat;
    assign dma_done  = (dma_win && (dma_len == 4'd0)) || burst_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            len_q        <= '0;
            base_q       <= '0;
            we_q         <= 1'b0;
            addr_last_q  <= '0;
            wdata_last_q <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dma_win) begin
                        len_q  <= dma_len;
                        base_q <= dma_addr;
                        we_q   <= dma_we;
                        if (dma_len != 4'd0) begin
                            state_q <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (burst_last) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (!dma_req || dma_win) begin
                starve_q <= '0;
            end else if (cpu_win && (starve_q < STARVE_LIM)) begin
                starve_q <= starve_q + 8'd1;
            end

            if (cpu_win || dma_beat) begin
                addr_last_q  <= mem_addr;
                wdata_last_q <= mem_wdata;
            end

            cpu_rvalid_q <= cpu_win & ~mem_we;
            dma_rvalid_q <= dma_beat & ~mem_we;
        end
    end

    assign cpu_rvalid     = cpu_rvalid_q;
    assign dma_rvalid     = dma_rvalid_q;
    assign cpu_rdata      = mem_rdata;
    assign dma_rdata      = mem_rdata;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: arbitration vector table, hand-written burst,
// wrap and reset sequences, then random traffic against a queue-based model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int STARVE = 3;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_beat, dma_done, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_len;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    state_e      dbg_state;
    logic [7:0]  dbg_starve_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_stall      (cpu_stall),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_len        (dma_len),
        .dma_gnt        (dma_gnt),
        .dma_beat       (dma_beat),
        .dma_done       (dma_done),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- clock / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    always @(posedge clk) mem_rdata <= pat(mem_addr);

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_len = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic        dma_req;
        logic        dma_we;
        logic [31:0] dma_addr;
        logic [3:0]  dma_len;
        logic        e_cpu_gnt;
        logic        e_cpu_stall;
        logic        e_dma_gnt;
        logic        e_dma_done;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        e_cpu_rv;
        logic        e_dma_rv;
    } vec_t;

    vec_t vecs[6];

    // ---------------- reference model state ----------------
    logic [31:0] burst_q[$];
    logic        m_bwe;
    int          m_starve;
    logic [31:0] m_last_addr, m_last_wd;
    logic        m_cpu_rv, m_dma_rv;

    initial begin
        logic        e_cg, e_dg, e_db, e_dd, e_we, e_stall;
        logic [31:0] e_addr, e_wd;

        vecs[0] = '{1'b1, 1'b0, 32'h60,  1'b0, 1'b0, 32'h0,   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60,  1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h90,  1'b1, 1'b0, 32'h500, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h90,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h7F0, 1'b0, 1'b1, 32'h300, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0};

        // reset state, with requests asserted to prove they are masked
        reset_n = 1'b0;
        idle_inputs();
        cpu_req = 1'b1;
        dma_req = 1'b1;
        #2;
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_dma_gnt", dma_gnt, 0);
        check("rst_dma_beat", dma_beat, 0);
        check("rst_dma_done", dma_done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_starve", dbg_starve_cnt, 0);
        do_reset();

        // table: one arbitration cycle, then an idle cycle to observe read return
        foreach (vecs[k]) begin
            next_cycle();
            cpu_req = vecs[k].cpu_req; cpu_we = vecs[k].cpu_we; cpu_addr = vecs[k].cpu_addr;
            cpu_wdata = 32'h1111_0000 + k;
            dma_req = vecs[k].dma_req; dma_we = vecs[k].dma_we; dma_addr = vecs[k].dma_addr;
            dma_len = vecs[k].dma_len; dma_wdata = 32'h2222_0000 + k;
            sample();
            check("vec_cpu_gnt", cpu_gnt, vecs[k].e_cpu_gnt);
            check("vec_cpu_stall", cpu_stall, vecs[k].e_cpu_stall);
            check("vec_dma_gnt", dma_gnt, vecs[k].e_dma_gnt);
            check("vec_dma_beat", dma_beat, vecs[k].e_dma_gnt);
            check("vec_dma_done", dma_done, vecs[k].e_dma_done);
            check("vec_mem_we", mem_we, vecs[k].e_mem_we);
            check("vec_mem_addr", mem_addr, vecs[k].e_mem_addr);
            next_cycle();
            idle_inputs();
            sample();
            check("vec_cpu_rvalid", cpu_rvalid, vecs[k].e_cpu_rv);
            check("vec_dma_rvalid", dma_rvalid, vecs[k].e_dma_rv);
            check("vec_hold_addr", mem_addr, vecs[k].e_mem_addr);
            check("vec_idle_we", mem_we, 0);
            if (vecs[k].e_cpu_rv) check("vec_cpu_rdata", cpu_rdata, pat(vecs[k].e_mem_addr));
            if (vecs[k].e_dma_rv) check("vec_dma_rdata", dma_rdata, pat(vecs[k].e_mem_addr));
        end

        // starvation: three CPU grants, then a 4-beat DMA read burst at 0x100
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40 + c * 4;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_len = 4'd3;
            sample();
            if (c < 3) begin
                check("starve_cpu_gnt", cpu_gnt, 1);
                check("starve_dma_gnt", dma_gnt, 0);
                check("starve_cpu_stall", cpu_stall, 0);
                check("starve_cnt", dbg_starve_cnt, c);
            end else begin
                check("starve_dma_wins", dma_gnt, 1);
                check("starve_cpu_lost", cpu_gnt, 0);
                check("starve_cnt_max", dbg_starve_cnt, STARVE);
                check("burst_addr0", mem_addr, 32'h100);
                check("burst_beat0", dma_beat, 1);
                check("burst_stall0", cpu_stall, 1);
                check("burst_done0", dma_done, 0);
                check("starve_cpu_rvalid", cpu_rvalid, 1);
                check("starve_cpu_rdata", cpu_rdata, pat(32'h48));
            end
        end
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            dma_addr = 32'hDEAD_0000; dma_len = 4'd0;
            if (i >= 2) dma_req = 1'b0;
            sample();
            if (i == 1) check("starve_cleared", dbg_starve_cnt, 0);
            check("burst_beat", dma_beat, 1);
            check("burst_no_gnt", dma_gnt, 0);
            check("burst_no_cpu", cpu_gnt, 0);
            check("burst_stall", cpu_stall, 1);
            check("burst_addr", mem_addr, 32'h100 + i * 4);
            check("burst_done", dma_done, i == 3);
            check("burst_rvalid", dma_rvalid, 1);
            check("burst_rdata", dma_rdata, pat(32'h100 + (i - 1) * 4));
        end
        next_cycle();
        cpu_addr = 32'h70;
        sample();
        check("post_burst_cpu_gnt", cpu_gnt, 1);
        check("post_burst_beat", dma_beat, 0);
        check("post_burst_rvalid", dma_rvalid, 1);
        check("post_burst_rdata", dma_rdata, pat(32'h10C));

        // address wrap on a 2-beat write burst
        next_cycle();
        idle_inputs();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hFFFF_FFFC; dma_len = 4'd1; dma_wdata = 32'hAAAA_0001;
        sample();
        check("wrap_gnt", dma_gnt, 1);
        check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
        check("wrap_we0", mem_we, 1);
        check("wrap_wdata0", mem_wdata, 32'hAAAA_0001);
        check("wrap_done0", dma_done, 0);
        next_cycle();
        dma_req = 1'b0; dma_wdata = 32'hAAAA_0002;
        sample();
        check("wrap_addr1", mem_addr, 32'h0);
        check("wrap_we1", mem_we, 1);
        check("wrap_wdata1", mem_wdata, 32'hAAAA_0002);
        check("wrap_done1", dma_done, 1);
        next_cycle();
        idle_inputs();
        sample();
        check("wrap_no_rvalid", dma_rvalid, 0);
        check("wrap_idle_we", mem_we, 0);
        check("wrap_hold_wdata", mem_wdata, 32'hAAAA_0002);

        // reset during beat 2 of an 8-beat burst
        next_cycle();
        dma_req = 1'b1; dma_addr = 32'h300; dma_len = 4'd7;
        sample();
        check("rb_beat0", mem_addr, 32'h300);
        next_cycle();
        dma_req = 1'b0;
        sample();
        check("rb_beat1", mem_addr, 32'h304);
        next_cycle();
        cpu_req = 1'b1;
        sample();
        check("rb_beat2", mem_addr, 32'h308);
        check("rb_cpu_blocked", cpu_gnt, 0);
        #1 reset_n = 1'b0;
        #1;
        check("rb_beat_off", dma_beat, 0);
        check("rb_done_off", dma_done, 0);
        check("rb_we_off", mem_we, 0);
        check("rb_addr_zero", mem_addr, 0);
        check("rb_cpu_gnt_off", cpu_gnt, 0);
        check("rb_rvalid_off", dma_rvalid, 0);
        check("rb_state", dbg_state, S_IDLE);
        @(posedge clk);
        #2 reset_n = 1'b1;
        sample();
        check("rb_first_cpu_gnt", cpu_gnt, 1);
        check("rb_no_beat", dma_beat, 0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            cpu_req = 1'b0;
            sample();
            check("rb_aborted", {dma_beat, dma_done}, 2'b00);
        end

        // random traffic against the model
        do_reset();
        burst_q.delete();
        m_bwe = 1'b0; m_starve = 0; m_last_addr = '0; m_last_wd = '0;
        m_cpu_rv = 1'b0; m_dma_rv = 1'b0;
        for (int n = 0; n < 500; n++) begin
            next_cycle();
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            dma_req   = $urandom_range(0, 1);
            dma_we    = $urandom_range(0, 1);
            dma_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            dma_len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            dma_wdata = $urandom;

            e_cg = 1'b0; e_dg = 1'b0; e_db = 1'b0; e_dd = 1'b0; e_we = 1'b0;
            e_addr = m_last_addr; e_wd = m_last_wd;
            if (burst_q.size() > 0) begin
                e_db = 1'b1; e_addr = burst_q.pop_front(); e_we = m_bwe; e_wd = dma_wdata;
                e_dd = (burst_q.size() == 0);
            end else if (cpu_req && (!dma_req || m_starve < STARVE)) begin
                e_cg = 1'b1; e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
            end else if (dma_req) begin
                e_dg = 1'b1; e_db = 1'b1; e_addr = dma_addr; e_we = dma_we; e_wd = dma_wdata;
                m_bwe = dma_we;
                for (int b = 1; b <= int'(dma_len); b++) burst_q.push_back(dma_addr + 32'(b * 4));
                e_dd = (dma_len == 4'd0);
            end
            e_stall = cpu_req && !e_cg;

            sample();
            check("rnd_cpu_gnt", cpu_gnt, e_cg);
            check("rnd_cpu_stall", cpu_stall, e_stall);
            check("rnd_dma_gnt", dma_gnt, e_dg);
            check("rnd_dma_beat", dma_beat, e_db);
            check("rnd_dma_done", dma_done, e_dd);
            check("rnd_mem_we", mem_we, e_we);
            check("rnd_mem_addr", mem_addr, e_addr);
            check("rnd_mem_wdata", mem_wdata, e_wd);
            check("rnd_starve", dbg_starve_cnt, m_starve);
            check("rnd_cpu_rvalid", cpu_rvalid, m_cpu_rv);
            check("rnd_dma_rvalid", dma_rvalid, m_dma_rv);
            if (m_cpu_rv) check("rnd_cpu_rdata", cpu_rdata, pat(m_last_addr));
            if (m_dma_rv) check("rnd_dma_rdata", dma_rdata, pat(m_last_addr));

            if (!dma_req || e_dg) m_starve = 0;
            else if (e_cg && m_starve < STARVE) m_starve++;
            m_last_addr = e_addr;
            m_last_wd   = e_wd;
            m_cpu_rv    = e_cg && !e_we;
            m_dma_rv    = e_db && !e_we;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
